// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the requester-side and memory-side signals of the
//             three-port memory arbiter.
//  Modports : slave  - the arbiter's view (takes requests and memory beats,
//                      drives grants, beat strobes and the memory command).
//             master - the environment's view (requesters plus memory).
//  Signals  : req_read/req_write[3], req_addr[60], req_wrdata[192],
//             grant/ready/err[3], rddata[32], mem_addr[20], mem_read,
//             mem_write, mem_wrdata[64], mem_ready, mem_rddata[32].
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    // Requester side; port i uses bit i, addr bits [20i+19:20i],
    // write data bits [64i+63:64i].
    logic [2:0]   req_read;
    logic [2:0]   req_write;
    logic [59:0]  req_addr;
    logic [191:0] req_wrdata;
    logic [2:0]   grant;
    logic [2:0]   ready;
    logic [2:0]   err;
    logic [31:0]  rddata;

    // Memory side.
    logic [19:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wrdata;
    logic         mem_ready;
    logic [31:0]  mem_rddata;

    modport slave (
        input  req_read, req_write, req_addr, req_wrdata,
        output grant, ready, err, rddata,
        output mem_addr, mem_read, mem_write, mem_wrdata,
        input  mem_ready, mem_rddata
    );

    modport master (
        output req_read, req_write, req_addr, req_wrdata,
        input  grant, ready, err, rddata,
        input  mem_addr, mem_read, mem_write, mem_wrdata,
        output mem_ready, mem_rddata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one external memory port between display scanout
//             (port 0, strict priority), texture cache (port 1) and the
//             framebuffer writer (port 2, round-robin with port 1). One
//             transaction is outstanding at a time; each completes as two
//             32-bit beats (high word first) that are returned to the owner.
//             A per-beat watchdog aborts stalled transactions.
//  Ports    : clk, rst (synchronous, active-high)
//             bus (mem_port_arbiter_if.slave) - requests, grants, beat
//             strobes, error strobes and the memory command/beat signals.
//  Params   : TIMEOUT - cycles allowed for each beat (2..255).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 63
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_beat_hi = 2'd1;
    localparam logic [1:0] c_beat_lo = 2'd2;

    // Counter value of the last cycle in which a beat is still accepted.
    localparam logic [7:0] c_last_wait = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,    state_d;
    logic [1:0]  owner_q,    owner_d;
    logic        is_write_q, is_write_d;
    logic [19:0] addr_q,     addr_d;
    logic [63:0] wrdata_q,   wrdata_d;
    logic [1:0]  rr_q,       rr_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic [2:0]  grant_q,    grant_d;
    logic [2:0]  ready_q,    ready_d;
    logic [2:0]  err_q,      err_d;
    logic [31:0] rddata_q,   rddata_d;

    logic [2:0]  w_req;
    logic [1:0]  w_win;
    logic        w_win_valid;
    logic [19:0] w_sel_addr;
    logic [63:0] w_sel_wrdata;
    logic        w_sel_write;
    logic        w_busy;
    logic        w_beat;
    logic        w_expire;

    function automatic logic [2:0] f_onehot(input logic [1:0] port);
        case (port)
            2'd0:    f_onehot = 3'b001;
            2'd1:    f_onehot = 3'b010;
            2'd2:    f_onehot = 3'b100;
            default: f_onehot = 3'b000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Arbitration: port 0 first, then ports 1/2 with rr_q as tie-breaker.
    // ------------------------------------------------------------------
    assign w_req       = bus.req_read | bus.req_write;
    assign w_win_valid = |w_req;

    always_comb begin
        w_win = 2'd0;
        if (w_req[0]) begin
            w_win = 2'd0;
        end else if (w_req[1] && w_req[2]) begin
            w_win = rr_q;
        end else if (w_req[1]) begin
            w_win = 2'd1;
        end else if (w_req[2]) begin
            w_win = 2'd2;
        end
    end

    // A port asserting both read and write is treated as a write.
    always_comb begin
        w_sel_addr   = bus.req_addr[19:0];
        w_sel_wrdata = bus.req_wrdata[63:0];
        w_sel_write  = bus.req_write[0];
        case (w_win)
            2'd1: begin
                w_sel_addr   = bus.req_addr[39:20];
                w_sel_wrdata = bus.req_wrdata[127:64];
                w_sel_write  = bus.req_write[1];
            end
            2'd2: begin
                w_sel_addr   = bus.req_addr[59:40];
                w_sel_wrdata = bus.req_wrdata[191:128];
                w_sel_write  = bus.req_write[2];
            end
            default: begin
                w_sel_addr   = bus.req_addr[19:0];
                w_sel_wrdata = bus.req_wrdata[63:0];
                w_sel_write  = bus.req_write[0];
            end
        endcase
    end

    // mem_ready counts in every beat-state cycle, including the command
    // cycle. A beat in the last permitted cycle wins over expiry.
    assign w_busy   = (state_q != c_idle);
    assign w_beat   = w_busy & bus.mem_ready;
    assign w_expire = w_busy & ~bus.mem_ready & (cnt_q == c_last_wait);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_idle;
            owner_q    <= 2'd0;
            is_write_q <= 1'b0;
            addr_q     <= 20'd0;
            wrdata_q   <= 64'd0;
            rr_q       <= 2'd1;
            cnt_q      <= 8'd0;
            grant_q    <= 3'b000;
            ready_q    <= 3'b000;
            err_q      <= 3'b000;
            rddata_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rddata_q   <= rddata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle: begin
                if (w_win_valid) begin
                    state_d = c_beat_hi;
                end
            end
            c_beat_hi: begin
                if (w_beat) begin
                    state_d = c_beat_lo;
                end else if (w_expire) begin
                    state_d = c_idle;
                end
            end
            c_beat_lo: begin
                if (w_beat || w_expire) begin
                    state_d = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        owner_d    = owner_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        grant_d    = 3'b000;
        ready_d    = 3'b000;
        err_d      = 3'b000;
        rddata_d   = rddata_q;

        if (!w_busy && w_win_valid) begin
            owner_d    = w_win;
            is_write_d = w_sel_write;
            addr_d     = w_sel_addr;
            wrdata_d   = w_sel_wrdata;
            grant_d    = f_onehot(w_win);
            cnt_d      = 8'd0;
            // Port-0 grants leave the 1/2 rotation untouched.
            if (w_win == 2'd1) begin
                rr_d = 2'd2;
            end else if (w_win == 2'd2) begin
                rr_d = 2'd1;
            end
        end else if (w_beat) begin
            ready_d  = f_onehot(owner_q);
            rddata_d = bus.mem_rddata;
            cnt_d    = 8'd0;
        end else if (w_expire) begin
            err_d = f_onehot(owner_q);
            cnt_d = 8'd0;
        end else if (w_busy) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // The command pulse coincides with the grant pulse.
    assign bus.grant      = grant_q;
    assign bus.ready      = ready_q;
    assign bus.err        = err_q;
    assign bus.rddata     = rddata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wrdata = wrdata_q;
    assign bus.mem_read   = (|grant_q) & ~is_write_q;
    assign bus.mem_write  = (|grant_q) &  is_write_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter: transaction-level
//             reference model, scripted memory responder with a small RAM,
//             and directed scenarios with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 63;

    logic clk;
    logic rst;
    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the outstanding transaction as owner, beats
    // remaining and an absolute deadline cycle; evaluated at each rising
    // edge, giving the outputs expected for the cycle that follows.
    // ------------------------------------------------------------------
    bit          m_valid = 0;
    bit          m_busy  = 0;
    bit          m_rst_cycle = 0;
    int          m_owner, m_beats, m_deadline;
    int          m_rr = 1;
    int          m_order[3];
    logic [2:0]  m_req;
    logic [2:0]  x_grant, x_ready, x_err;
    logic        x_rd, x_wr;
    logic [31:0] x_rddata;
    logic [19:0] x_addr;
    logic [63:0] x_wdata;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        x_grant = 3'b000; x_ready = 3'b000; x_err = 3'b000;
        x_rd = 1'b0; x_wr = 1'b0; m_rst_cycle = 1'b0;
        if (rst) begin
            m_valid = 1; m_busy = 0; m_rr = 1; m_rst_cycle = 1;
            x_rddata = '0; x_addr = '0; x_wdata = '0;
        end else if (m_valid) begin
            if (m_busy) begin
                if (bus.mem_ready) begin
                    x_ready    = 3'b001 << m_owner;
                    x_rddata   = bus.mem_rddata;
                    m_beats    = m_beats - 1;
                    m_deadline = cyc + TIMEOUT;
                    if (m_beats == 0) m_busy = 0;
                end else if (cyc == m_deadline) begin
                    x_err  = 3'b001 << m_owner;
                    m_busy = 0;
                end
            end else begin
                m_req = bus.req_read | bus.req_write;
                m_order[0] = 0; m_order[1] = m_rr; m_order[2] = 3 - m_rr;
                for (int k = 0; k < 3; k++) begin
                    if (!m_busy && m_req[m_order[k]]) begin
                        m_busy     = 1;
                        m_owner    = m_order[k];
                        m_beats    = 2;
                        m_deadline = cyc + TIMEOUT;
                        x_grant    = 3'b001 << m_owner;
                        x_wr       = bus.req_write[m_owner];
                        x_rd       = !bus.req_write[m_owner];
                        x_addr     = bus.req_addr[m_owner*20 +: 20];
                        x_wdata    = bus.req_wrdata[m_owner*64 +: 64];
                        if (m_owner != 0) m_rr = 3 - m_owner;
                    end
                end
            end
        end
    end

    // Compare process: mid-cycle against the model's expectations.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("ctrl{grant,ready,err,rd,wr}",
                  {53'd0, bus.grant, bus.ready, bus.err, bus.mem_read, bus.mem_write},
                  {53'd0, x_grant, x_ready, x_err, x_rd, x_wr});
            if (x_ready != 3'b000) check("rddata", {32'd0, bus.rddata}, {32'd0, x_rddata});
            if (m_busy || m_rst_cycle) begin
                check("mem_addr", {44'd0, bus.mem_addr}, {44'd0, x_addr});
                check("mem_wrdata", bus.mem_wrdata, x_wdata);
            end
            if (m_rst_cycle) check("rddata_rst", {32'd0, bus.rddata}, 64'd0);
        end
    end

    // ------------------------------------------------------------------
    // Memory responder: beat 1 at command+mem_d1, beat 2 at command+mem_d2
    // (negative disables a beat). Beats use the live address/write data.
    // ------------------------------------------------------------------
    logic [31:0] ram [0:1023];
    int          mem_d1 = -1, mem_d2 = -1;
    int          mc_cmd = -1, mc_d1 = -1, mc_d2 = -1;
    logic        mc_wr = 1'b0;

    task automatic mem_beat(input int idx);
        logic [9:0]  a;
        logic [31:0] w;
        a = bus.mem_addr[9:0] + 10'(idx);
        if (mc_wr) begin
            w = (idx == 0) ? bus.mem_wrdata[63:32] : bus.mem_wrdata[31:0];
            ram[a] = w;
        end else begin
            w = ram[a];
        end
        bus.mem_rddata = w;
        bus.mem_ready  = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA5000000 | i;
        bus.mem_ready  = 1'b0;
        bus.mem_rddata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) begin
                mc_cmd = cyc; mc_wr = bus.mem_write; mc_d1 = mem_d1; mc_d2 = mem_d2;
            end
            bus.mem_ready = 1'b0;
            if (mc_cmd >= 0 && mc_d1 >= 0 && cyc == mc_cmd + mc_d1) mem_beat(0);
            else if (mc_cmd >= 0 && mc_d2 >= 0 && cyc == mc_cmd + mc_d2) mem_beat(1);
        end
    end

    // ------------------------------------------------------------------
    // Event log of grants, beat strobes and error strobes.
    // ------------------------------------------------------------------
    int          lg_port[$], lg_cyc[$], lr_port[$], lr_cyc[$], le_port[$], le_cyc[$];
    logic [19:0] lg_addr[$];
    logic        lg_wr[$];
    logic [31:0] lr_data[$];

    initial forever begin
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            if (bus.grant[p] === 1'b1) begin
                lg_port.push_back(p); lg_cyc.push_back(cyc);
                lg_addr.push_back(bus.mem_addr); lg_wr.push_back(bus.mem_write);
            end
            if (bus.ready[p] === 1'b1) begin
                lr_port.push_back(p); lr_cyc.push_back(cyc); lr_data.push_back(bus.rddata);
            end
            if (bus.err[p] === 1'b1) begin
                le_port.push_back(p); le_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        lg_port.delete(); lg_cyc.delete(); lg_addr.delete(); lg_wr.delete();
        lr_port.delete(); lr_cyc.delete(); lr_data.delete();
        le_port.delete(); le_cyc.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers; all are entered and left just after a falling edge.
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctrl_addr_rddata",
              {1'b0, bus.grant, bus.ready, bus.err, bus.mem_read, bus.mem_write,
               bus.mem_addr, bus.rddata}, 64'd0);
        check("reset_wrdata", bus.mem_wrdata, 64'd0);
        rst = 1'b0;
    endtask

    task automatic do_req(input int p, input bit wr, input logic [19:0] a,
                          input logic [63:0] d, output int rc, output int gc);
        bit got;
        bus.req_addr[p*20 +: 20]   = a;
        bus.req_wrdata[p*64 +: 64] = d;
        if (wr) bus.req_write[p] = 1'b1;
        else    bus.req_read[p]  = 1'b1;
        rc  = cyc;
        gc  = -1;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus.grant[p] === 1'b1) begin got = 1; gc = cyc; end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL grant_wait: port %0d saw no grant within 300 cycles", p);
        end
        @(negedge clk);
        bus.req_read[p]  = 1'b0;
        bus.req_write[p] = 1'b0;
    endtask

    task automatic wait_grant();
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.grant !== 3'b000) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL grant_wait: no grant within 200 cycles");
        end
    endtask

    int rc, gc;

    initial begin
        rst = 1'b1;
        bus.req_read = 3'b000; bus.req_write = 3'b000;
        bus.req_addr = '0;     bus.req_wrdata = '0;
        do_reset();

        // Port-1 read at 0x00456, beats 27 and 31 cycles after the command.
        clear_logs();
        mem_d1 = 27; mem_d2 = 31;
        do_req(1, 1'b0, 20'h00456, 64'd0, rc, gc);
        repeat (35) @(negedge clk);
        check("t1_req_to_grant", 64'(gc - rc), 64'd1);
        check("t1_grant_count", 64'(lg_port.size()), 64'd1);
        if (lg_port.size() > 0) begin
            check("t1_grant_port", 64'(lg_port[0]), 64'd1);
            check("t1_mem_addr", {44'd0, lg_addr[0]}, 64'h00456);
            check("t1_is_read", {63'd0, lg_wr[0]}, 64'd0);
        end
        check("t1_ready_count", 64'(lr_port.size()), 64'd2);
        if (lr_port.size() == 2) begin
            check("t1_ready_port", 64'(lr_port[0] * 4 + lr_port[1]), 64'd5);
            check("t1_hi_word", {32'd0, lr_data[0]}, 64'hA5000056);
            check("t1_lo_word", {32'd0, lr_data[1]}, 64'hA5000057);
            check("t1_hi_latency", 64'(lr_cyc[0] - gc), 64'd28);
            check("t1_lo_latency", 64'(lr_cyc[1] - gc), 64'd32);
        end

        // Port-2 write of 0x0123456789ABCDEF at 0x00010.
        clear_logs();
        mem_d1 = 2; mem_d2 = 5;
        do_req(2, 1'b1, 20'h00010, 64'h0123456789ABCDEF, rc, gc);
        repeat (8) @(negedge clk);
        if (lg_port.size() > 0) check("t2_is_write", {63'd0, lg_wr[0]}, 64'd1);
        check("t2_ram_hi", {32'd0, ram[16]}, 64'h01234567);
        check("t2_ram_lo", {32'd0, ram[17]}, 64'h89ABCDEF);
        check("t2_ready_count", 64'(lr_port.size()), 64'd2);
        if (lr_port.size() == 2) begin
            check("t2_ready_port", 64'(lr_port[0] * 4 + lr_port[1]), 64'd10);
            check("t2_echo_hi", {32'd0, lr_data[0]}, 64'h01234567);
        end

        // Ports 1 and 2 requesting continuously from reset.
        do_reset();
        clear_logs();
        mem_d1 = 2; mem_d2 = 4;
        bus.req_addr = {20'h00200, 20'h00100, 20'h00000};
        bus.req_read = 3'b110;
        for (int i = 0; i < 4; i++) wait_grant();
        bus.req_read = 3'b000;
        repeat (8) @(negedge clk);
        check("t3_grant_count", 64'(lg_port.size()), 64'd4);
        if (lg_port.size() == 4)
            check("t3_order_1212", 64'(lg_port[0]*1000 + lg_port[1]*100 + lg_port[2]*10 + lg_port[3]), 64'd1212);

        // Port 0 competing with ports 1 and 2; rotation between 1/2 kept.
        clear_logs();
        for (int it = 0; it < 2; it++) begin
            bus.req_read = 3'b111;
            wait_grant();
            @(negedge clk);
            bus.req_read[0] = 1'b0;
            wait_grant();
            @(negedge clk);
            bus.req_read = 3'b000;
            repeat (8) @(negedge clk);
        end
        check("t4_grant_count", 64'(lg_port.size()), 64'd4);
        if (lg_port.size() == 4)
            check("t4_order_0102", 64'(lg_port[0]*1000 + lg_port[1]*100 + lg_port[2]*10 + lg_port[3]), 64'd102);

        // Second beat never arrives: one err to the owner, then recovery.
        clear_logs();
        mem_d1 = 3; mem_d2 = -1;
        do_req(1, 1'b0, 20'h00040, 64'd0, rc, gc);
        repeat (72) @(negedge clk);
        check("t5_err_count", 64'(le_port.size()), 64'd1);
        if (le_port.size() == 1) begin
            check("t5_err_port", 64'(le_port[0]), 64'd1);
            check("t5_err_latency", 64'(le_cyc[0] - gc), 64'(3 + 1 + TIMEOUT));
        end
        check("t5_ready_count", 64'(lr_port.size()), 64'd1);
        clear_logs();
        mem_d1 = 1; mem_d2 = 2;
        do_req(2, 1'b0, 20'h00020, 64'd0, rc, gc);
        repeat (4) @(negedge clk);
        check("t5_recover_latency", 64'(gc - rc), 64'd1);
        check("t5_recover_ready", 64'(lr_port.size()), 64'd2);

        // Both beats in the last permitted cycle of their windows.
        clear_logs();
        mem_d1 = TIMEOUT - 1; mem_d2 = 2 * TIMEOUT - 1;
        do_req(1, 1'b0, 20'h00080, 64'd0, rc, gc);
        repeat (2 * TIMEOUT + 4) @(negedge clk);
        check("t5b_no_err", 64'(le_port.size()), 64'd0);
        check("t5b_ready_count", 64'(lr_port.size()), 64'd2);
        if (lr_port.size() == 2)
            check("t5b_lo_latency", 64'(lr_cyc[1] - gc), 64'(2 * TIMEOUT));

        // First beat never arrives.
        clear_logs();
        mem_d1 = -1; mem_d2 = -1;
        do_req(2, 1'b0, 20'h00090, 64'd0, rc, gc);
        repeat (TIMEOUT + 4) @(negedge clk);
        check("t5c_err_count", 64'(le_port.size()), 64'd1);
        if (le_port.size() == 1) begin
            check("t5c_err_port", 64'(le_port[0]), 64'd2);
            check("t5c_err_latency", 64'(le_cyc[0] - gc), 64'(TIMEOUT));
        end

        // Reset during BEAT_LO of a read; the late second beat is ignored.
        clear_logs();
        mem_d1 = 2; mem_d2 = 10;
        do_req(1, 1'b0, 20'h00300, 64'd0, rc, gc);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_ctrl_addr_rddata",
              {1'b0, bus.grant, bus.ready, bus.err, bus.mem_read, bus.mem_write,
               bus.mem_addr, bus.rddata}, 64'd0);
        check("t6_reset_wrdata", bus.mem_wrdata, 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_ready_count", 64'(lr_port.size()), 64'd1);
        check("t6_err_count", 64'(le_port.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL global_timeout: bench did not complete by time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
